// File: rtl/issue_unit_rr_pkg.sv
// rtl/issue_unit_rr_pkg.sv - shared GPGPU warp constants and one-hot/binary helpers
package issue_unit_rr_pkg;

  // Number of warps in the core; arbiters and pending vectors are this wide
  localparam int NUM_WARPS = 8;
  // Warp ID width, log2(NUM_WARPS)
  localparam int WID_W = 3;

  // One-hot (or all-zero) warp vector to binary warp ID; all-zero maps to 0
  function automatic logic [WID_W-1:0] onehot_to_bin(input logic [NUM_WARPS-1:0] oh);
    logic [WID_W-1:0] b;
    b = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (oh[i]) b = b | i[WID_W-1:0];
    end
    return b;
  endfunction

  // Binary warp ID to one-hot warp vector
  function automatic logic [NUM_WARPS-1:0] bin_to_onehot(input logic [WID_W-1:0] b);
    logic [NUM_WARPS-1:0] oh;
    oh = '0;
    oh[b] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/issue_unit_rr_arbiter8.sv
// rtl/issue_unit_rr_arbiter8.sv - combinational 8-way round-robin arbiter
module rr_arbiter8
  import issue_unit_rr_pkg::*;
(
  input  logic [NUM_WARPS-1:0] ready,
  input  logic [WID_W-1:0]     ptr,
  output logic [NUM_WARPS-1:0] grant
);

  logic             found;
  logic [WID_W-1:0] idx;

  // Scan from ptr upward with natural 3-bit wrap; first ready warp wins
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_WARPS; k++) begin
      idx = ptr + k[WID_W-1:0];
      if (!found && ready[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_unit_rr.sv
// rtl/issue_unit_rr.sv - round-robin warp issue unit with branch blocking and OC back-pressure
module issue_unit_rr
  import issue_unit_rr_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_WARPS-1:0] IB_Ready_Issue_IU,
  output logic [NUM_WARPS-1:0] IU_Grant,
  input  logic                 OC_Full,
  input  logic                 BEQ_Out,
  input  logic                 BLT_Out,
  input  logic                 Branch_Resolve_Valid,
  input  logic [WID_W-1:0]     Branch_Resolve_WarpID,
  output logic                 Issue_Valid_OC,
  output logic [WID_W-1:0]     Issue_WarpID_OC,
  output logic [NUM_WARPS-1:0] Branch_Pending
);

  logic [WID_W-1:0]     ptr_q;
  logic [NUM_WARPS-1:0] pend_q;
  logic [NUM_WARPS-1:0] pend_d;
  logic [NUM_WARPS-1:0] eligible;
  logic                 issue_ok;
  logic                 is_branch;

  // rst_n gates eligibility so the grant drops the instant reset asserts,
  // without waiting for a clock edge. BEQ/BLT never feed this path.
  assign issue_ok = ~OC_Full & rst_n;
  assign eligible = IB_Ready_Issue_IU & ~pend_q & {NUM_WARPS{issue_ok}};

  rr_arbiter8 u_arb (
    .ready (eligible),
    .ptr   (ptr_q),
    .grant (IU_Grant)
  );

  assign Issue_Valid_OC  = |IU_Grant;
  assign Issue_WarpID_OC = onehot_to_bin(IU_Grant);
  assign Branch_Pending  = pend_q;
  assign is_branch       = BEQ_Out | BLT_Out;

  // Next pending vector: resolve clears first, then a new branch issue sets,
  // so a same-warp set/clear collision leaves the warp blocked
  always_comb begin
    pend_d = pend_q;
    if (Branch_Resolve_Valid) begin
      pend_d = pend_d & ~bin_to_onehot(Branch_Resolve_WarpID);
    end
    if (Issue_Valid_OC && is_branch) begin
      pend_d = pend_d | IU_Grant;
    end
  end

  // Round-robin pointer advances past each granted warp; holds when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (Issue_Valid_OC) begin
      ptr_q <= Issue_WarpID_OC + 3'd1;
    end
  end

  // Per-warp branch-blocked bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: tb/tb_issue_unit_rr.sv
// tb/tb_issue_unit_rr.sv - scoreboard bench for issue_unit_rr
module tb_issue_unit_rr;

  logic       clk;
  logic       rst_n;
  logic [7:0] ib_ready;
  logic [7:0] iu_grant;
  logic       oc_full;
  logic       beq;
  logic       blt;
  logic       rv;
  logic [2:0] rwid;
  logic       issue_valid;
  logic [2:0] issue_wid;
  logic [7:0] branch_pending;

  typedef struct packed {
    logic [7:0] grant;
    logic [7:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;

  issue_unit_rr dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .IB_Ready_Issue_IU     (ib_ready),
    .IU_Grant              (iu_grant),
    .OC_Full               (oc_full),
    .BEQ_Out               (beq),
    .BLT_Out               (blt),
    .Branch_Resolve_Valid  (rv),
    .Branch_Resolve_WarpID (rwid),
    .Issue_Valid_OC        (issue_valid),
    .Issue_WarpID_OC       (issue_wid),
    .Branch_Pending        (branch_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] wid_of(input logic [7:0] g);
    logic [2:0] w;
    w = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (g[i]) w = i[2:0];
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue the expected outputs
  task automatic step(input logic r, input logic [7:0] rdy, input logic ocf,
                      input logic b_eq, input logic b_lt, input logic res_v,
                      input logic [2:0] res_w, input logic [7:0] eg, input logic [7:0] ep);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n    = r;
    ib_ready = rdy;
    oc_full  = ocf;
    beq      = b_eq;
    blt      = b_lt;
    rv       = res_v;
    rwid     = res_w;
    e.grant  = eg;
    e.pend   = ep;
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("grant", iu_grant, e.grant);
      check("valid", {7'd0, issue_valid}, {7'd0, |e.grant});
      check("warp_id", {5'd0, issue_wid}, {5'd0, wid_of(e.grant)});
      check("pending", branch_pending, e.pend);
    end
  end

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    ib_ready = 8'h00;
    oc_full  = 1'b0;
    beq      = 1'b0;
    blt      = 1'b0;
    rv       = 1'b0;
    rwid     = 3'd0;

    // reset: grant stays low even with every warp ready
    step(0, 8'hFF, 0, 0, 0, 0, 3'd0, 8'h00, 8'h00);

    // 1: full rotation then wrap back to warp 0
    step(1, 8'hFF, 0, 0, 0, 0, 3'd0, 8'h01, 8'h00);
    step(1, 8'hFF, 0, 0, 0, 0, 3'd0, 8'h02, 8'h00);
    step(1, 8'hFF, 0, 0, 0, 0, 3'd0, 8'h04, 8'h00);
    step(1, 8'hFF, 0, 0, 0, 0, 3'd0, 8'h08, 8'h00);
    step(1, 8'hFF, 0, 0, 0, 0, 3'd0, 8'h10, 8'h00);
    step(1, 8'hFF, 0, 0, 0, 0, 3'd0, 8'h20, 8'h00);
    step(1, 8'hFF, 0, 0, 0, 0, 3'd0, 8'h40, 8'h00);
    step(1, 8'hFF, 0, 0, 0, 0, 3'd0, 8'h80, 8'h00);
    step(1, 8'hFF, 0, 0, 0, 0, 3'd0, 8'h01, 8'h00);

    // 2: grant warp 4 (ptr->5), then wrap to warp 0, then warp 2
    step(1, 8'h10, 0, 0, 0, 0, 3'd0, 8'h10, 8'h00);
    step(1, 8'h05, 0, 0, 0, 0, 3'd0, 8'h01, 8'h00);
    step(1, 8'h05, 0, 0, 0, 0, 3'd0, 8'h04, 8'h00);

    // 3: BEQ on warp 3 blocks it until resolve
    step(1, 8'h08, 0, 1, 0, 0, 3'd0, 8'h08, 8'h00);
    step(1, 8'h08, 0, 0, 0, 0, 3'd0, 8'h00, 8'h08);
    step(1, 8'h08, 0, 0, 0, 0, 3'd0, 8'h00, 8'h08);
    step(1, 8'h08, 0, 0, 0, 1, 3'd3, 8'h00, 8'h08);
    step(1, 8'h08, 0, 0, 0, 0, 3'd0, 8'h08, 8'h00);

    // 4: OC back-pressure freezes ptr at 4
    step(1, 8'hFF, 1, 0, 0, 0, 3'd0, 8'h00, 8'h00);
    step(1, 8'hFF, 1, 0, 0, 0, 3'd0, 8'h00, 8'h00);
    step(1, 8'hFF, 1, 0, 0, 0, 3'd0, 8'h00, 8'h00);
    step(1, 8'hFF, 0, 0, 0, 0, 3'd0, 8'h10, 8'h00);

    // 5: warp 2 pending; resolve 2 while warp 6 issues BLT
    step(1, 8'h04, 0, 0, 1, 0, 3'd0, 8'h04, 8'h00);
    step(1, 8'h40, 0, 0, 1, 1, 3'd2, 8'h40, 8'h04);
    step(1, 8'h00, 0, 0, 0, 0, 3'd0, 8'h00, 8'h40);
    // same-warp set and clear on warp 1: set wins
    step(1, 8'h02, 0, 1, 0, 1, 3'd1, 8'h02, 8'h40);
    step(1, 8'h00, 0, 0, 0, 0, 3'd0, 8'h00, 8'h42);
    // resolve of a non-pending warp is harmless; clear 1 then 6
    step(1, 8'h00, 0, 0, 0, 1, 3'd1, 8'h00, 8'h42);
    step(1, 8'h00, 0, 0, 0, 1, 3'd6, 8'h00, 8'h40);
    step(1, 8'h00, 0, 0, 0, 1, 3'd4, 8'h00, 8'h00);

    // 6: build pending 81 and ptr 6, then reset mid-stream
    step(1, 8'h01, 0, 1, 0, 0, 3'd0, 8'h01, 8'h00);
    step(1, 8'h80, 0, 1, 0, 0, 3'd0, 8'h80, 8'h01);
    step(1, 8'h20, 0, 0, 0, 0, 3'd0, 8'h20, 8'h81);
    step(0, 8'hFF, 0, 0, 0, 0, 3'd0, 8'h00, 8'h00);
    step(1, 8'h0C, 0, 0, 0, 0, 3'd0, 8'h04, 8'h00);
    step(1, 8'h0C, 0, 0, 0, 0, 3'd0, 8'h08, 8'h00);

    begin
      int guard;
      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
        @(posedge clk);
        guard++;
      end
      if (exp_q.size() > 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
